nibble_serial_adder: RTL



---
 rtl/nibble_serial_adder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide adder that runs one 4-bit CLA slice over the
// operands, least-significant nibble first, with a registered carry between
// nibbles. Operands enter and the result leaves through valid/ready ports.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   input  logic                   Cin,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [4*NIBBLES-1:0]   S,
   output logic                   Cout,
   output logic                   Ovf,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam int WIDTH = 4 * NIBBLES;
   // Counter must hold at least one bit even when only one nibble exists.
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic               carry_reg, carry_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]   s_reg, s_next;
   logic               cout_reg, cout_next;
   logic               ovf_reg, ovf_next;

   logic [3:0]         a_nib [NIBBLES];
   logic [3:0]         b_nib [NIBBLES];
   logic [3:0]         slice_a, slice_b, slice_s;
   logic               slice_cout;

   // Split the captured operands into nibbles and steer the slice sum back
   // into the nibble of S selected by the counter; other nibbles hold.
   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign s_next[4*gi +: 4] = (state_reg == RUN && cnt_reg == CNT_W'(gi))
                                 ? slice_s : s_reg[4*gi +: 4];
   end

   assign slice_a = a_nib[cnt_reg];
   assign slice_b = b_nib[cnt_reg];

   CLA_4bit u_slice (
      .S    (slice_s),
      .Cout (slice_cout),
      .A    (slice_a),
      .B    (slice_b),
      .Cin  (carry_reg)
   );

   // Next-state logic and Moore outputs of the sequencer.
   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      carry_next = carry_reg;
      cnt_next   = cnt_reg;
      cout_next  = cout_reg;
      ovf_next   = ovf_reg;
      in_ready   = 1'b0;
      busy       = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_next     = A;
               b_next     = B;
               carry_next = Cin;
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            busy       = 1'b1;
            carry_next = slice_cout;
            if (cnt_reg == LAST_CNT) begin
               // The slice sum bit 3 on the last nibble is the final sign bit.
               cout_next  = slice_cout;
               ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (slice_s[3] != a_reg[WIDTH-1]);
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight addition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         s_reg     <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         carry_reg <= carry_next;
         cnt_reg   <= cnt_next;
         s_reg     <= s_next;
         cout_reg  <= cout_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign S    = s_reg;
   assign Cout = cout_reg;
   assign Ovf  = ovf_reg;

endmodule

// CLA_4bit: 4-bit carry-lookahead slice with all carries computed in
// parallel from generate/propagate terms.
module CLA_4bit (
   output logic [3:0] S,
   output logic       Cout,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin
);

   logic [3:0] g, p;
   logic [4:0] c;

   // Lookahead carry equations and sum bits.
   always_comb begin
      g    = A & B;
      p    = A ^ B;
      c[0] = Cin;
      c[1] = g[0] | (p[0] & Cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
             (p[2] & p[1] & p[0] & Cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
             (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);
      S    = p ^ c[3:0];
      Cout = c[4];
   end

endmodule
